// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad responder.
// Optional contact bounce is enabled with `KEYPAD_BOUNCE_EN.
package keypad_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t PRESS   = 2'd1;
    localparam state_t HOLD    = 2'd2;
    localparam state_t RELEASE = 2'd3;

    localparam logic [3:0] ROW_NONE  = 4'b1111;
    localparam logic [3:0] ROW_FIRST = 4'b1110;

    function automatic logic [3:0] onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic logic row_legal(input logic [3:0] r);
        return (r == 4'b1110) || (r == 4'b1101) ||
               (r == 4'b1011) || (r == 4'b0111);
    endfunction

endpackage

// File: rtl/keypad_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used as the bounce noise source.
// Only instantiated when `KEYPAD_BOUNCE_EN is defined.
module keypad_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic out
);

    logic [7:0] q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
    end

    assign out = q[0];

endmodule

// File: rtl/keypad_emulator.sv
// Keypad responder: drives active-low columns for one scripted key press.
// Define `KEYPAD_BOUNCE_EN to add LFSR contact bounce at press/release.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int         HOLD_SCANS    = 4,
    parameter int         RELEASE_SCANS = 2,
    parameter int         BOUNCE_CYCLES = 256,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] column,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic       busy,
    output logic       done
);

    state_t     state;
    state_t     state_nx;
    logic [7:0] scan_cnt;
    logic [3:0] row_prev;
    logic [3:0] key;
    logic [3:0] col_nx;
    logic       scan;
    logic       row_hit;

    // A scan starts when row enters 1110 from any other value.
    assign scan = row_legal(row) && (row == ROW_FIRST) &&
                  (row_prev != ROW_FIRST);

    assign row_hit = row_legal(row) && (row == onehot_low(key[3:2]));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (key_valid) state_nx = PRESS;
            PRESS:   if (row == ROW_FIRST) state_nx = HOLD;
            HOLD:    if (scan_cnt == 8'(HOLD_SCANS)) state_nx = RELEASE;
            RELEASE: if (scan_cnt == 8'(RELEASE_SCANS)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign key_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == RELEASE) &&
                       (scan_cnt == 8'(RELEASE_SCANS));

`ifdef KEYPAD_BOUNCE_EN
    localparam int BW = $clog2(BOUNCE_CYCLES + 1);

    logic [BW-1:0] bounce_cnt;
    logic          bouncing;
    logic          noise;

    keypad_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .out (noise)
    );

    assign bouncing = (bounce_cnt < BW'(BOUNCE_CYCLES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bounce_cnt <= '0;
        end else if (state_nx != state) begin
            bounce_cnt <= '0;
        end else if (bouncing) begin
            bounce_cnt <= bounce_cnt + BW'(1);
        end
    end

    // During bounce the matched bit carries noise in HOLD and RELEASE.
    always_comb begin
        col_nx = ROW_NONE;
        if (row_hit && (state == HOLD || state == RELEASE)) begin
            if (bouncing) begin
                col_nx[key[1:0]] = noise;
            end else if (state == HOLD) begin
                col_nx = onehot_low(key[1:0]);
            end
        end
    end
`else
    always_comb begin
        col_nx = ROW_NONE;
        if (row_hit && (state == HOLD)) begin
            col_nx = onehot_low(key[1:0]);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            scan_cnt <= '0;
            row_prev <= ROW_NONE;
            key      <= '0;
            column   <= ROW_NONE;
        end else begin
            state    <= state_nx;
            row_prev <= row;
            column   <= col_nx;
            if (state == IDLE && key_valid) begin
                key <= key_code;
            end
            if (state_nx != state) begin
                scan_cnt <= '0;
            end else if (scan && scan_cnt != 8'hFF) begin
                scan_cnt <= scan_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: vector table, directed
// sequences and randomized scanning against a behavioural model.
module tb_keypad_emulator;

    localparam int HS  = 4;
    localparam int RS  = 2;
    localparam int BNC = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row = 4'hF;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] column;
    logic       key_ready;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    keypad_emulator #(
        .HOLD_SCANS    (HS),
        .RELEASE_SCANS (RS),
        .BOUNCE_CYCLES (BNC),
        .LFSR_SEED     (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .column    (column),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] rows[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] ill[4]  = '{4'b1111, 4'b0000, 4'b1100, 4'b1001};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h at %0t",
                      nm, act, exp, $time);
    endtask

    // Behavioural model: phase 0 idle, 1 waiting for scan, 2 held, 3 released.
    int         m_ph;
    int         m_scans;
    int         m_bcnt;
    logic [3:0] m_prev;
    logic [3:0] m_key;
    logic [3:0] m_col;
    logic [7:0] m_lfsr;

    task automatic model_reset();
        m_ph = 0; m_scans = 0; m_bcnt = 0;
        m_prev = 4'hF; m_key = 4'h0;
        m_col = 4'hF; m_lfsr = 8'hA5;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic v,
                              input logic [3:0] c);
        int   nph;
        logic new_scan;
        logic hit;
        new_scan = (r == 4'b1110) && (m_prev != 4'b1110);
        hit = ($countones(~r) == 1) &&
              (r == (4'hF ^ (4'd1 << m_key[3:2])));
        m_col = 4'hF;
`ifdef KEYPAD_BOUNCE_EN
        if (hit && (m_ph == 2 || m_ph == 3) && m_bcnt < BNC)
            m_col[m_key[1:0]] = m_lfsr[0];
        else if (hit && m_ph == 2)
            m_col = 4'hF ^ (4'd1 << m_key[1:0]);
`else
        if (hit && m_ph == 2)
            m_col = 4'hF ^ (4'd1 << m_key[1:0]);
`endif
        nph = m_ph;
        case (m_ph)
            0: if (v) begin nph = 1; m_key = c; end
            1: if (r == 4'b1110) nph = 2;
            2: if (m_scans == HS) nph = 3;
            default: if (m_scans == RS) nph = 0;
        endcase
        if (nph != m_ph) m_scans = 0;
        else if (new_scan && m_scans < 255) m_scans++;
        if (nph != m_ph) m_bcnt = 0;
        else if (m_bcnt < BNC) m_bcnt++;
        m_lfsr = {m_lfsr[6:0],
                  m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_ph = nph;
        m_prev = r;
    endtask

    task automatic cyc(input logic [3:0] r, input logic v,
                       input logic [3:0] c);
        row = r; key_valid = v; key_code = c;
        @(posedge clk);
        model_edge(r, v, c);
        #1;
        chk("column", column, m_col);
        chk("key_ready", key_ready, m_ph == 0);
        chk("busy", busy, m_ph != 0);
        chk("done", done, m_ph == 3 && m_scans == RS);
    endtask

    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_column", column, 4'hF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", key_ready, 1'b1);
        chk("rst_done", done, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        logic [3:0] code;
        logic [3:0] r;
        logic [3:0] col;
    } vec_t;

    vec_t tbl[11];

    int wins, dones, first, hits, bad, guard;
    logic prevhit, acc9, v;

    initial begin
        tbl[0]  = '{4'd5,  4'b1101, 4'b1101};
        tbl[1]  = '{4'd5,  4'b1011, 4'b1111};
        tbl[2]  = '{4'd15, 4'b0111, 4'b0111};
        tbl[3]  = '{4'd0,  4'b1110, 4'b1110};
        tbl[4]  = '{4'd9,  4'b1011, 4'b1101};
        tbl[5]  = '{4'd6,  4'b1101, 4'b1011};
        tbl[6]  = '{4'd12, 4'b0111, 4'b1110};
        tbl[7]  = '{4'd5,  4'b1111, 4'b1111};
        tbl[8]  = '{4'd5,  4'b0000, 4'b1111};
        tbl[9]  = '{4'd5,  4'b1100, 4'b1111};
        tbl[10] = '{4'd3,  4'b1110, 4'b0111};

        model_reset();
        #12;
        chk("init_column", column, 4'hF);
        chk("init_ready", key_ready, 1'b1);
        chk("init_busy", busy, 1'b0);
        chk("init_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        // Column decode in HOLD, then async abort mid-HOLD.
        for (int i = 0; i < 11; i++) begin
            cyc(4'hF, 1'b1, tbl[i].code);
            cyc(4'b1110, 1'b0, 4'h0);
            cyc(tbl[i].r, 1'b0, 4'h0);
            chk("tbl_col", column, tbl[i].col);
            do_reset();
        end

        // Key 5 over a regular 8-clk scan: four pressed windows, one done.
        cyc(4'hF, 1'b1, 4'd5);
        wins = 0; dones = 0; prevhit = 1'b0;
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 8; j++) begin
                    cyc(rows[k], 1'b0, 4'h0);
                    if ((column == 4'b1101) && !prevhit) wins++;
                    prevhit = (column == 4'b1101);
                    if (done) dones++;
                end
        chk("t1_windows", wins, 4);
        chk("t1_done", dones, 1);
        chk("t1_ready", key_ready, 1'b1);

        // Key 15 requested mid-scan: press waits for the next scan start.
        for (int k = 0; k < 2; k++)
            for (int j = 0; j < 8; j++) cyc(rows[k], 1'b0, 4'h0);
        cyc(rows[2], 1'b1, 4'd15);
        for (int j = 0; j < 7; j++) cyc(rows[2], 1'b0, 4'h0);
        for (int j = 0; j < 8; j++) cyc(rows[3], 1'b0, 4'h0);
        first = -1;
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 8; j++) begin
                    cyc(rows[k], 1'b0, 4'h0);
                    if (first < 0 && column == 4'b0111) first = s * 4 + k;
                end
        chk("t2_first", first, 3);

        // Request held through busy: code 9 only lands once ready.
        cyc(4'hF, 1'b1, 4'd3);
        acc9 = 1'b0; hits = 0; bad = 0;
        for (int s = 0; s < 20; s++)
            for (int k = 0; k < 4; k++)
                for (int j = 0; j < 8; j++) begin
                    v = !acc9;
                    if (v && m_ph == 0) acc9 = 1'b1;
                    else v = v && (m_ph != 0);
                    cyc(rows[k], v, (s < 2) ? 4'd3 : 4'd9);
                    if (acc9 && !v && column != 4'hF) begin
                        if (rows[k] == 4'b1011 && column == 4'b1101) hits++;
                        else bad++;
                    end
                end
        chk("t3_accepted", acc9, 1'b1);
        chk("t3_hits", hits > 0, 1'b1);
        chk("t3_bad", bad, 0);

        guard = 0;
        while (m_ph != 0 && guard < 2000) begin
            cyc(rows[(guard / 8) % 4], 1'b0, 4'h0);
            guard++;
        end
        chk("idle_timeout", guard < 2000, 1'b1);

        // Randomized scanning with glitches, requests and resets.
        begin
            int idx, cnt, per;
            logic [3:0] r;
            idx = 0; cnt = 0; per = 4;
            for (int n = 0; n < 4000; n++) begin
                if (cnt == per) begin
                    cnt = 0;
                    idx = (idx + 1) % 4;
                    if (idx == 0) per = $urandom_range(2, 9);
                end
                r = rows[idx];
                if ($urandom_range(0, 19) == 0) r = ill[$urandom_range(0, 3)];
                cyc(r, $urandom_range(0, 3) == 0, 4'($urandom));
                cnt++;
                if ($urandom_range(0, 799) == 0) do_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
